mc_mainfsm: RTL

Main control state machine for the multicycle ARMv4-subset core (ADD/SUB/AND/ORR, LDR/STR, B). It replaces the single-cycle main decoder. Each instruction is sequenced over 3-5+ cycles on a shared memory and ALU. It emits Moore-style datapath enables and mux selects, and stalls in memory states until the memory/I-O side signals mem_ready, so slow ports (e.g. the port at 0x800) can hold the core. It also counts retired instructions and flags undefined opcodes.

---
 rtl/mc_pkg.sv | 31 +++
 rtl/mc_mainfsm_retire_counter.sv | 17 +
 rtl/mc_mainfsm.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types for the multicycle ARM control unit.
// State codes, datapath select encodings and opcode classes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

endpackage

// File: rtl/mc_mainfsm_retire_counter.sv
// Wrapping event counter, cleared by async active-low reset.
// Ports: clk, resetE, inc (count enable) -> count.
module retire_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetE,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge resetE) begin
    if (!resetE) count <= '0;
    else if (inc) count <= count + CNT_WIDTH'(1);
  end

endmodule

// File: rtl/mc_mainfsm.sv
// Main control FSM of the multicycle core: Moore enables/selects,
// mem_ready stalls, illegal-op flag and retired-instruction count.
module mc_mainfsm
  import mc_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int WAIT_EN   = 1
) (
  input  logic                 clk,
  input  logic                 resetE,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic                 mem_ready,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 Branch,
  output logic                 ALUOp,
  output logic                 illegal,
  output logic [3:0]           state_dbg,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_t state, next;
  logic   rdy;
  logic   retire;
  logic   unused;

  // Without wait states every access completes at once.
  assign rdy       = mem_ready | (WAIT_EN == 0);
  assign state_dbg = state;
  assign unused    = ^Funct[4:1];

  always_ff @(posedge clk or negedge resetE) begin
    if (!resetE) state <= S_FETCH;
    else         state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_FETCH:  if (rdy) next = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_DP:   next = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  next = S_MEMADR;
          OP_BR:   next = S_BRANCH;
          default: next = S_FETCH;
        endcase
      end
      S_MEMADR: next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (rdy) next = S_MEMWB;
      S_MEMWR:  if (rdy) next = S_FETCH;
      S_MEMWB:  next = S_FETCH;
      S_EXECR:  next = S_ALUWB;
      S_EXECI:  next = S_ALUWB;
      S_ALUWB:  next = S_FETCH;
      S_BRANCH: next = S_FETCH;
      default:  next = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        IRWrite   = rdy;
        NextPC    = rdy;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALU;
        illegal   = (Op == OP_BAD);
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = rdy;
        retire = rdy;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
        retire    = 1'b1;
      end
      S_EXECR:  ALUOp = 1'b1;
      S_EXECI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        RegW   = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
    // Reset kills every enable at once so an aborted STR never writes.
    if (!resetE) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      Branch  = 1'b0;
      illegal = 1'b0;
      retire  = 1'b0;
    end
  end

  retire_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_retire (
    .clk   (clk),
    .resetE(resetE),
    .inc   (retire),
    .count (instr_count)
  );

endmodule
